// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DMEM_OOR_ERR_EN (out-of-range error reporting).
package dmem_responder_pkg;

  localparam int DMEM_BYTES = 8;  // byte lanes per 64-bit word
  localparam int DMEM_OFF_W = 3;  // byte-offset bits inside a word

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit word array with byte-strobed synchronous write and a
// registered read port, both driven by a single access enable.
// A store returns zero on the read port; clr zeroes the read register.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     wen,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DMEM_BYTES-1:0]    wstrb,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];

  // Byte-lane write on an enabled store access.
  // NOTE: the storage array is deliberately not reset; its contents are undefined after reset and only the read register is cleared.
  always_ff @(posedge clk) begin
    if (en && wen) begin
      for (int b = 0; b < DMEM_BYTES; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read: old word on a load, zero on a store, zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= wen ? '0 : mem[idx];
    end else if (clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs the
// array access LATENCY cycles after acceptance and holds the response
// until the initiator takes it.
// Optional feature macro: DMEM_OOR_ERR_EN -- addresses >= DEPTH*8 return
// o_rsp_err=1 and suppress stores; otherwise addresses wrap modulo DEPTH.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic                  i_req_wen,
  input  logic [DMEM_BYTES-1:0] i_req_wstrb,
  input  logic [DATA_W-1:0]     i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e               state;
  logic [CNT_W-1:0]          cnt;
  logic [ADDR_W-1:0]         addr_q;
  logic                      wen_q;
  logic [DMEM_BYTES-1:0]     wstrb_q;
  logic [DATA_W-1:0]         wdata_q;
  logic                      rsp_valid_q;
  logic                      err_q;

  logic                      access;
  logic                      rsp_take;
  logic                      oor;
  logic                      unused_addr;
  logic [63:0]               arr_rdata;
  dmem_rsp_t                 rsp;

  // Out-of-range detection on the captured address; low offset bits are
  // never used because alignment is checked by the initiator.
`ifdef DMEM_OOR_ERR_EN
  assign oor         = |addr_q[ADDR_W-1:IDX_W+DMEM_OFF_W];
  assign unused_addr = ^addr_q[DMEM_OFF_W-1:0];
`else
  assign oor         = 1'b0;
  assign unused_addr = ^{addr_q[ADDR_W-1:IDX_W+DMEM_OFF_W], addr_q[DMEM_OFF_W-1:0]};
`endif

  assign access   = (state == DMEM_WAIT) && (cnt == '0);
  assign rsp_take = (state == DMEM_RESP) && i_rsp_ready;

  // An out-of-range access is turned into a zero-strobe store: nothing is
  // written and the read register returns zero.
  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (access),
    .wen   (wen_q | oor),
    .clr   (rsp_take),
    .idx   (addr_q[DMEM_OFF_W +: IDX_W]),
    .wstrb (oor ? '0 : wstrb_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Request/response FSM with latency counter and captured request.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DMEM_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (i_req_valid) begin
            addr_q  <= i_req_addr;
            wen_q   <= i_req_wen;
            wstrb_q <= i_req_wstrb;
            wdata_q <= i_req_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_valid_q <= 1'b1;
            err_q       <= oor;
            state       <= DMEM_RESP;
          end
        end
        DMEM_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state       <= DMEM_IDLE;
          end
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

  assign rsp         = '{rdata: arr_rdata, err: err_q};
  assign o_req_ready = (state == DMEM_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp.rdata;
  assign o_rsp_err   = rsp.err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the data-memory request/response interface. The memory stage is the initiator; this block is the data-memory side that serves it.
- Accepts one load or store request at a time over a valid/ready handshake and performs a byte-strobed access on an internal word array after a programmable latency.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Replaces the fixed single-cycle data memory when multi-cycle memory timing is modelled.

Parameters:
- ADDR_W, 64, request address width (matches `ALEN)
- DATA_W, 64, data width in bits; fixed at 64, 8 byte lanes
- DEPTH, 1024, number of 64-bit words; power of two
- LATENCY, 2, cycles from request acceptance to response valid; minimum 1

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- i_req_valid  input  1  request valid
- o_req_ready  output  1  request ready
- i_req_addr  input  ADDR_W  byte address
- i_req_wen  input  1  1 = store, 0 = load
- i_req_wstrb  input  8  byte-lane write enables; ignored on loads
- i_req_wdata  input  64  store data, lane-aligned
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response accepted by initiator
- o_rsp_rdata  output  64  load data; 0 for store responses
- o_rsp_err  output  1  out-of-range error; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0; latency counter=0; captured request registers=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- o_req_ready=1 only in IDLE.
- IDLE:
  - On i_req_valid&&o_req_ready, capture addr, wen, wstrb and wdata; load cnt=LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the array access on this edge and go to RESP with o_rsp_valid=1.
- Array access:
  - Word index = addr[$clog2(DEPTH)+2:3]; addr[2:0] is ignored (alignment is checked upstream).
  - Store: for each lane b with wstrb[b]=1, write mem[idx][8b+7:8b]=wdata[8b+7:8b]; o_rsp_rdata=0.
  - Load: o_rsp_rdata=mem[idx] as held before this edge.
  - A store with wstrb=0 is legal: no array change, response still returned.
- RESP:
  - o_rsp_valid, o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready=1.
  - On that edge: o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, go to IDLE.
  - No request is accepted in the same cycle. Minimum request spacing is LATENCY+2 cycles.
- Latency: request accepted at edge T; o_rsp_valid rises after edge T+LATENCY.
- Address wrap-around: without the optional feature, the index is the address modulo DEPTH words.
- Reset mid-operation: the pending request is dropped. A store whose access edge has not yet occurred is never committed. Any held response is discarded.
- Request inputs are sampled only on the acceptance edge; later changes are ignored.

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined:
  - A request with addr >= DEPTH*8 sets o_rsp_err=1 in RESP, with o_rsp_rdata=0.
  - A store to such an address is suppressed; the array is unchanged.
  - Timing is identical to a normal access.
- Undefined:
  - Out-of-range addresses wrap modulo DEPTH.
  - o_rsp_err is constant 0.

Decomposition:
- Shared package:
  - FSM state enum (DMEM_IDLE, DMEM_WAIT, DMEM_RESP).
  - Constants DMEM_BYTES=8 and DMEM_OFF_W=3.
  - Response struct {rdata, err}.
- Sub-module dmem_array: DEPTH×64 byte-strobed synchronous-write array with registered read on a single access enable.
- FSM, latency counter and handshake stay in dmem_responder.

Test Plan (DEPTH=1024, LATENCY=2):
- Store then load: store addr 0x10, wdata 0x1122334455667788, wstrb 0xFF; then load 0x10 -> load response rdata 0x1122334455667788; o_rsp_valid rises exactly 2 cycles after each acceptance.
- Partial store: over the word above, store wdata 0xAA00000000000000, wstrb 0x80; then load 0x10 -> rdata 0xAA22334455667788.
- Response backpressure: hold i_rsp_ready=0 for 5 cycles after o_rsp_valid -> rdata stable, o_req_ready=0 throughout; a new request is accepted only in the cycle after the response handshake.
- Wrap versus error: store to 0x2010 (8208 ≥ 8192) with wstrb 0xFF:
  - Without macro: the store aliases word 2 (0x10); reading 0x10 returns the new data.
  - With DMEM_OOR_ERR_EN: o_rsp_err=1 and the word at 0x10 is unchanged.
- Reset mid-WAIT: accept a store to 0x18, assert rst_n=0 one cycle later -> all outputs 0, FSM in IDLE; a subsequent load of 0x18 returns the value held before the store.
- LATENCY=1 build: back-to-back requests with i_rsp_ready held high -> o_rsp_valid 1 cycle after each acceptance; one request per 3 cycles.
